// File: rtl/stack_list_sequencer_pkg.sv
// Shared types and constants for the multi-register push/pop sequencer.
package stack_list_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRANSFER,
    ST_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    MEM_NORMAL = 3'd0,
    MEM_PUSH   = 3'd1,
    MEM_POP    = 3'd2
  } mem_ctl_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int unsigned GPR_COUNT = 8;
  localparam int unsigned LR_INDEX  = 14;
  localparam int unsigned PC_INDEX  = 15;

endpackage

// File: rtl/stack_list_sequencer_bit_scan.sv
// Combinational priority scan: position of the highest (lowest=0) or lowest (lowest=1) set bit.
module bit_scan #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned POS_WIDTH = 4
) (
  input  logic [WIDTH-1:0]     vec,
  input  logic                 lowest,
  output logic [POS_WIDTH-1:0] pos
);

  always_comb begin
    pos = '0;
    if (lowest) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (vec[WIDTH-1-i]) pos = POS_WIDTH'(WIDTH-1-i);
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (vec[i]) pos = POS_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/stack_list_sequencer.sv
// Sequences a PUSH/POP register list into one stack beat per cycle, with the
// POP writeback delayed one cycle to cover the synchronous memory read.
module stack_list_sequencer
  import stack_list_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LIST_WIDTH  = 9,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [LIST_WIDTH-1:0]  reg_list,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             mem_control,
  output logic                   mem_write_enable,
  output logic [INDEX_WIDTH-1:0] reg_index,
  output logic                   reg_write_enable,
  output logic [INDEX_WIDTH-1:0] wb_index
);

  localparam int unsigned POS_WIDTH = (LIST_WIDTH > 1) ? $clog2(LIST_WIDTH) : 1;

  if (DATA_WIDTH < 1 || INDEX_WIDTH < 4) begin : g_param_check
    $error("stack_list_sequencer: DATA_WIDTH must be >= 1 and INDEX_WIDTH >= 4");
  end

  seq_state_e            state;
  logic                  op_q;
  logic [LIST_WIDTH-1:0] pending;

  logic [LIST_WIDTH-1:0]  scan_vec;
  logic                   scan_lowest;
  logic [POS_WIDTH-1:0]   scan_pos;
  logic [INDEX_WIDTH-1:0] beat_index;
  logic [LIST_WIDTH-1:0]  remaining;

  // In IDLE the first beat is chosen straight from reg_list so that beats start
  // the cycle after acceptance; afterwards pending holds the bits still to go.
  always_comb begin
    scan_vec    = (state == ST_IDLE) ? reg_list : pending;
    scan_lowest = (state == ST_IDLE) ? op : op_q;
  end

  bit_scan #(
    .WIDTH     (LIST_WIDTH),
    .POS_WIDTH (POS_WIDTH)
  ) u_bit_scan (
    .vec    (scan_vec),
    .lowest (scan_lowest),
    .pos    (scan_pos)
  );

  always_comb begin
    if (32'(scan_pos) < GPR_COUNT) beat_index = INDEX_WIDTH'(scan_pos);
    else if (scan_lowest)          beat_index = INDEX_WIDTH'(PC_INDEX);
    else                           beat_index = INDEX_WIDTH'(LR_INDEX);
    remaining = scan_vec & ~(LIST_WIDTH'(1) << scan_pos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      op_q             <= OP_PUSH;
      pending          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_control      <= MEM_NORMAL;
      mem_write_enable <= 1'b0;
      reg_index        <= '0;
      reg_write_enable <= 1'b0;
      wb_index         <= '0;
    end else begin
      reg_write_enable <= (mem_control == MEM_POP);
      wb_index         <= (mem_control == MEM_POP) ? reg_index : '0;
      mem_control      <= MEM_NORMAL;
      mem_write_enable <= 1'b0;
      reg_index        <= '0;
      done             <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            op_q <= op;
            if (reg_list != '0) begin
              state            <= ST_TRANSFER;
              pending          <= remaining;
              mem_control      <= (op == OP_POP) ? MEM_POP : MEM_PUSH;
              mem_write_enable <= (op == OP_PUSH);
              reg_index        <= beat_index;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_TRANSFER: begin
          if (pending != '0) begin
            pending          <= remaining;
            mem_control      <= (op_q == OP_POP) ? MEM_POP : MEM_PUSH;
            mem_write_enable <= (op_q == OP_PUSH);
            reg_index        <= beat_index;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          pending <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_list_sequencer.sv
// Scoreboard bench: the driver queues the expected per-cycle output trace, the monitor pops and compares.
module tb_stack_list_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] mc;
    logic       mwe;
    logic [3:0] ri;
    logic       rwe;
    logic [3:0] wi;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [8:0] reg_list;
  logic       busy;
  logic       done;
  logic [2:0] mem_control;
  logic       mem_write_enable;
  logic [3:0] reg_index;
  logic       reg_write_enable;
  logic [3:0] wb_index;

  rec_t exp_q[$];
  rec_t trace[$];
  rec_t act;
  int   tests = 0;
  int   fails = 0;
  bit   end_req = 0;
  bit   end_done = 0;

  stack_list_sequencer #(
    .DATA_WIDTH  (32),
    .LIST_WIDTH  (9),
    .INDEX_WIDTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .op               (op),
    .reg_list         (reg_list),
    .busy             (busy),
    .done             (done),
    .mem_control      (mem_control),
    .mem_write_enable (mem_write_enable),
    .reg_index        (reg_index),
    .reg_write_enable (reg_write_enable),
    .wb_index         (wb_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {busy, done, mem_control, mem_write_enable, reg_index, reg_write_enable, wb_index};

  // Reference: order the selected registers, then lay out one record per busy cycle.
  function automatic void build_trace(input logic o, input logic [8:0] l);
    int   idx[$];
    rec_t r;
    trace.delete();
    if (o == 1'b0) begin
      for (int b = 8; b >= 0; b--) if (l[b]) idx.push_back(b == 8 ? 14 : b);
    end else begin
      for (int b = 0; b <= 8; b++) if (l[b]) idx.push_back(b == 8 ? 15 : b);
    end
    for (int k = 0; k < idx.size(); k++) begin
      r      = '0;
      r.busy = 1'b1;
      r.mc   = o ? 3'd2 : 3'd1;
      r.mwe  = !o;
      r.ri   = 4'(idx[k]);
      if (o && k > 0) begin
        r.rwe = 1'b1;
        r.wi  = 4'(idx[k-1]);
      end
      trace.push_back(r);
    end
    r      = '0;
    r.busy = 1'b1;
    r.done = 1'b1;
    if (o && idx.size() > 0) begin
      r.rwe = 1'b1;
      r.wi  = 4'(idx[idx.size()-1]);
    end
    trace.push_back(r);
  endfunction

  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      tests++;
      if (act !== '0) begin
        fails++;
        $display("FAIL reset_outputs got %h want 0000", act);
      end
    end else if (act !== '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_activity t=%0t got busy=%b done=%b mc=%0d we=%b ri=%0d rwe=%b wi=%0d want idle",
                 $time, act.busy, act.done, act.mc, act.mwe, act.ri, act.rwe, act.wi);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL beat t=%0t got busy=%b done=%b mc=%0d we=%b ri=%0d rwe=%b wi=%0d want busy=%b done=%b mc=%0d we=%b ri=%0d rwe=%b wi=%0d",
                   $time, act.busy, act.done, act.mc, act.mwe, act.ri, act.rwe, act.wi,
                   e.busy, e.done, e.mc, e.mwe, e.ri, e.rwe, e.wi);
        end
      end
    end
    if (end_req && !end_done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_beats got %0d outstanding want 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic run_txn(input logic o, input logic [8:0] l, input bit noisy);
    int n;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    reg_list = l;
    build_trace(o, l);
    foreach (trace[i]) exp_q.push_back(trace[i]);
    n = trace.size();
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        op       = 1'($urandom_range(0, 1));
        reg_list = 9'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic reset_mid_pop();
    @(negedge clk);
    start    = 1'b1;
    op       = 1'b1;
    reg_list = 9'h0FF;
    build_trace(1'b1, 9'h0FF);
    exp_q.push_back(trace[0]);
    exp_q.push_back(trace[1]);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic       o;
    logic [8:0] l;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    reg_list = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_txn(1'b0, 9'h109, 1'b0);
    run_txn(1'b1, 9'h106, 1'b0);
    run_txn(1'b0, 9'h000, 1'b0);
    idle_cycles(2);
    run_txn(1'b1, 9'h000, 1'b1);
    run_txn(1'b0, 9'h109, 1'b1);
    run_txn(1'b1, 9'h1FF, 1'b1);
    run_txn(1'b0, 9'h1FF, 1'b1);
    idle_cycles(1);
    reset_mid_pop();
    run_txn(1'b0, 9'h001, 1'b0);
    idle_cycles(3);

    for (int t = 0; t < 60; t++) begin
      o = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom);
      run_txn(o, l, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(4);
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    if (!end_done) begin
      tests++;
      fails++;
      $display("FAIL end_check got not_reached want reached");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_list_sequencer.md
STACK_LIST_SEQUENCER -- requirements
Module: stack_list_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the CPU word width (passed through only; no datapath arithmetic).
REQ-002 SHALL have parameter LIST_WIDTH, default 9: bits 0-7 select r0-r7; bit 8 selects LR (push) or PC (pop).
REQ-003 SHALL have parameter INDEX_WIDTH, default 4, the register-index width.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a multi-register transfer; sampled only in IDLE.
REQ-007 op  input  1  0 = PUSH, 1 = POP; sampled with start.
REQ-008 reg_list  input  LIST_WIDTH  register selection mask; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until DONE completes; used as the CPU stall.
REQ-010 done  output  1  one-cycle pulse marking the end of a transfer.
REQ-011 mem_control  output  3  control code for the memory address handler: 0 = normal, 1 = PUSH, 2 = POP.
REQ-012 mem_write_enable  output  1  stack memory write strobe for push beats.
REQ-013 reg_index  output  INDEX_WIDTH  register read or load for the current beat.
REQ-014 reg_write_enable  output  1  register-file write strobe for pop writeback.
REQ-015 wb_index  output  INDEX_WIDTH  destination register for reg_write_enable.

Function
REQ-016 SHALL implement the FSM states IDLE, TRANSFER and DONE.
REQ-017 IDLE, start=1, reg_list!=0: SHALL latch op and reg_list into pending, then go to TRANSFER.
REQ-018 IDLE, start=1, reg_list=0: SHALL go to DONE with no memory or register beat.
REQ-019 start while busy SHALL be ignored; start while done is high SHALL also be ignored.
REQ-020 TRANSFER SHALL issue exactly one beat per cycle for the selected set bit, then clear that bit in pending.
REQ-021 When the bit cleared in REQ-020 is the last set bit in pending, the FSM SHALL go to DONE.
REQ-022 PUSH order: highest set bit first, so LR is pushed before r7..r0 (full-descending stack).
REQ-023 POP order: lowest set bit first, so PC is popped last.
REQ-024 Bit mapping: bits 0-7 map to index 0-7; bit 8 maps to index 14 on PUSH and 15 on POP.
REQ-025 PUSH beat: mem_control=1, mem_write_enable=1, reg_index=mapped index, all in the same cycle.
REQ-026 POP beat: mem_control=2 and reg_index=mapped index in beat cycle k.
REQ-027 POP writeback: reg_write_enable=1 and wb_index=(index of beat k) in cycle k+1, covering the one-cycle synchronous memory read latency.
REQ-028 The last POP writeback SHALL coincide with the DONE cycle.
REQ-029 DONE SHALL last one cycle with done=1, mem_control=0, mem_write_enable=0, then return to IDLE.
REQ-030 Outside beat cycles: mem_control=0, mem_write_enable=0, reg_index=0.
REQ-031 Outside writeback cycles: reg_write_enable=0, wb_index=0.
REQ-032 For N set bits, busy SHALL be high for exactly N+1 cycles; for an empty list, busy SHALL be high for 1 cycle.
REQ-033 mem_control SHALL never take values other than 0, 1 or 2.

Reset
REQ-034 reset low SHALL immediately force IDLE and clear pending and the latched op.
REQ-035 reset low SHALL force busy=0, done=0, mem_control=0, mem_write_enable=0, reg_write_enable=0, reg_index=0 and wb_index=0.
REQ-036 A reset mid-transfer SHALL suppress any outstanding POP writeback.
REQ-037 After reset deasserts, the first accepted start SHALL begin a new transfer.

Structure
REQ-038 The shared package SHALL hold the FSM state encoding.
REQ-039 The shared package SHALL hold the mem_control codes (NORMAL=0, PUSH=1, POP=2) and the LR=14 and PC=15 constants.
REQ-040 One sub-module, bit_scan, SHALL be combinational: it returns the highest or lowest set-bit position of pending, selected by a direction input.

Verification
REQ-041 PUSH {r0,r3,LR} (op=0, list=0x109) -> 3 beats with reg_index 14,3,0, mem_control=1, mem_write_enable=1, then done; busy high 4 cycles.
REQ-042 POP {r1,r2,PC} (op=1, list=0x106) -> mem_control=2 beats with reg_index 1,2,15; wb_index 1,2,15 each one cycle later; the last writeback coincides with done.
REQ-043 start with list=0x000 -> done the next cycle, busy high 1 cycle, no mem_control, mem_write_enable or reg_write_enable activity.
REQ-044 start pulsed during an active transfer (any op or list) -> ignored; beat sequence and count unchanged.
REQ-045 reset asserted during the second beat of POP list 0x0FF -> all outputs 0 immediately, no further writeback; a new PUSH list=0x001 after release -> single beat with index 0.
REQ-046 Back-to-back start held high through done -> second transfer begins only from IDLE, one cycle after done.
